// File: rtl/core_seq_ctl.sv
// Multi-cycle control sequencer: fetch, decode, execute, data access and writeback,
// with a saturating retired-instruction counter and a memory-wait timeout trap.
module core_seq_ctl #(
    parameter int CNT_W   = 32,
    parameter int TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             start,
    input  logic             imem_ready,
    input  logic             dmem_ready,
    input  logic             mem_read,
    input  logic             mem_write,
    input  logic             reg_write,
    input  logic             branch_uc,
    input  logic             branch_c,
    input  logic             jump_reg,
    input  logic             halt_instr,
    input  logic             br_taken,
    output logic [2:0]       state,
    output logic             imem_req,
    output logic             ir_we,
    output logic             dmem_req,
    output logic             dmem_we,
    output logic             rf_we,
    output logic             pc_we,
    output logic [1:0]       pc_src,
    output logic             busy,
    output logic             err,
    output logic [CNT_W-1:0] retired
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_IDLE   = 3'd5,
        S_HALT   = 3'd6,
        S_ERR    = 3'd7
    } state_t;

    localparam int                WAIT_W   = $clog2(TIMEOUT);
    localparam logic [WAIT_W-1:0] WAIT_LIM = WAIT_W'(TIMEOUT - 1);

    state_t            st;
    logic [WAIT_W-1:0] wait_cnt;
    logic [1:0]        pc_src_q;
    logic [1:0]        exec_src;
    logic              is_mem;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    assign is_mem = mem_read | mem_write;
    assign state  = st;

    always_comb begin
        exec_src = 2'd0;
        if (jump_reg)
            exec_src = 2'd2;
        else if (branch_uc | (branch_c & br_taken))
            exec_src = 2'd1;
    end

    // Strobes decode from the registered state; ir_we and the EXEC/MEM retire
    // strobes also look at this cycle's inputs so they land without an extra cycle.
    always_comb begin
        imem_req = 1'b0;
        ir_we    = 1'b0;
        dmem_req = 1'b0;
        dmem_we  = 1'b0;
        rf_we    = 1'b0;
        pc_we    = 1'b0;
        pc_src   = pc_src_q;
        busy     = 1'b0;
        err      = 1'b0;
        case (st)
            S_FETCH: begin
                busy     = 1'b1;
                imem_req = 1'b1;
                ir_we    = imem_ready;
            end
            S_DECODE: busy = 1'b1;
            S_EXEC: begin
                busy   = 1'b1;
                pc_src = exec_src;
                pc_we  = ~is_mem & ~reg_write;
            end
            S_MEM: begin
                busy     = 1'b1;
                dmem_req = 1'b1;
                dmem_we  = mem_write;
                pc_we    = dmem_ready & ~mem_read;
            end
            S_WB: begin
                busy  = 1'b1;
                rf_we = 1'b1;
                pc_we = 1'b1;
            end
            S_ERR:   err = 1'b1;
            S_IDLE:  ;
            S_HALT:  ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            st       <= S_IDLE;
            wait_cnt <= '0;
            pc_src_q <= 2'd0;
            retired  <= '0;
        end else begin
            if (pc_we)
                retired <= sat_inc(retired);
            case (st)
                S_IDLE: begin
                    wait_cnt <= '0;
                    if (start)
                        st <= S_FETCH;
                end
                // A ready on the limit cycle still completes the access.
                S_FETCH: begin
                    if (imem_ready) begin
                        st       <= S_DECODE;
                        wait_cnt <= '0;
                    end else if (wait_cnt == WAIT_LIM) begin
                        st <= S_ERR;
                    end else begin
                        wait_cnt <= wait_cnt + WAIT_W'(1);
                    end
                end
                S_DECODE: st <= halt_instr ? S_HALT : S_EXEC;
                S_EXEC: begin
                    pc_src_q <= exec_src;
                    wait_cnt <= '0;
                    if (is_mem)
                        st <= S_MEM;
                    else if (reg_write)
                        st <= S_WB;
                    else
                        st <= S_FETCH;
                end
                S_MEM: begin
                    if (dmem_ready) begin
                        st       <= mem_read ? S_WB : S_FETCH;
                        wait_cnt <= '0;
                    end else if (wait_cnt == WAIT_LIM) begin
                        st <= S_ERR;
                    end else begin
                        wait_cnt <= wait_cnt + WAIT_W'(1);
                    end
                end
                S_WB:   st <= S_FETCH;
                S_HALT: ;
                S_ERR:  ;
            endcase
        end
    end

endmodule

// File: tb/tb_core_seq_ctl.sv
// Bench for core_seq_ctl: instruction-level trace model (per-instruction cycle lists
// built from latency rules) compared against the DUT every cycle, plus literal pins.
module tb_core_seq_ctl;
    localparam int CNT_W   = 4;
    localparam int TIMEOUT = 16;

    logic clk = 1'b0;
    logic rstn = 1'b0, start = 1'b0, imem_ready = 1'b0, dmem_ready = 1'b0;
    logic mem_read = 1'b0, mem_write = 1'b0, reg_write = 1'b0, branch_uc = 1'b0;
    logic branch_c = 1'b0, jump_reg = 1'b0, halt_instr = 1'b0, br_taken = 1'b0;
    logic [2:0]       state;
    logic             imem_req, ir_we, dmem_req, dmem_we, rf_we, pc_we, busy, err;
    logic [1:0]       pc_src;
    logic [CNT_W-1:0] retired;

    core_seq_ctl #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rstn(rstn), .start(start), .imem_ready(imem_ready),
        .dmem_ready(dmem_ready), .mem_read(mem_read), .mem_write(mem_write),
        .reg_write(reg_write), .branch_uc(branch_uc), .branch_c(branch_c),
        .jump_reg(jump_reg), .halt_instr(halt_instr), .br_taken(br_taken),
        .state(state), .imem_req(imem_req), .ir_we(ir_we), .dmem_req(dmem_req),
        .dmem_we(dmem_we), .rf_we(rf_we), .pc_we(pc_we), .pc_src(pc_src),
        .busy(busy), .err(err), .retired(retired)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       start, iready, dready;
        logic [2:0] st;
        logic       imem_req, ir_we, dmem_req, dmem_we, rf_we, pc_we;
        logic [1:0] pc_src;
        logic       busy, err;
        int         ret;
    } cyc_t;

    typedef enum int {K_ALU, K_JAL, K_JALR, K_LOAD, K_STORE, K_BR, K_HALT} kind_t;

    cyc_t plan[$];
    cyc_t exp_q[$];
    int   obs[$];
    int   checks = 0;
    int   errors = 0;
    int   m_ret  = 0;
    int   m_src  = 0;
    logic c_mr, c_mw, c_rw, c_uc, c_bc, c_jr, c_halt, c_tk;
    int   t1_exp[5] = '{5, 0, 1, 2, 4};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: actual=%0d expected=%0d", name, $time, act, exp);
        end
    endtask

    function automatic logic rbit();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic cyc_t mk(input int st);
        cyc_t c;
        c.start = 1'b0; c.iready = 1'b0; c.dready = 1'b0;
        c.st = 3'(st);
        c.imem_req = 1'b0; c.ir_we = 1'b0; c.dmem_req = 1'b0; c.dmem_we = 1'b0;
        c.rf_we = 1'b0; c.pc_we = 1'b0;
        c.pc_src = 2'(m_src);
        c.busy = (st <= 4);
        c.err = (st == 7);
        c.ret = 0;
        return c;
    endfunction

    function automatic int count_state(input int s);
        int n = 0;
        foreach (obs[i]) if (obs[i] == s) n++;
        return n;
    endfunction

    task automatic build_idle(input int n_wait);
        cyc_t c;
        for (int i = 0; i <= n_wait; i++) begin
            c = mk(5);
            c.start = (i == n_wait);
            plan.push_back(c);
        end
    endtask

    // One instruction as a list of expected cycles: (wi+1) fetch, decode,
    // exec, (wd+1) memory, writeback -- truncated into ERR/HALT as applicable.
    task automatic build_instr(input kind_t k, input int wi, input int wd, input logic br);
        cyc_t c;
        {c_mr, c_mw, c_rw, c_uc, c_bc, c_jr, c_halt} = '0;
        c_tk = rbit();
        case (k)
            K_ALU:   c_rw = 1'b1;
            K_JAL:   begin c_rw = 1'b1; c_uc = 1'b1; end
            K_JALR:  begin c_rw = 1'b1; c_uc = 1'b1; c_jr = 1'b1; end
            K_LOAD:  begin c_mr = 1'b1; c_rw = 1'b1; end
            K_STORE: c_mw = 1'b1;
            K_BR:    begin c_bc = 1'b1; c_tk = br; end
            K_HALT:  c_halt = 1'b1;
        endcase
        for (int i = 0; i <= wi && i < TIMEOUT; i++) begin
            c = mk(0);
            c.imem_req = 1'b1;
            c.iready = (i == wi);
            c.ir_we = (i == wi);
            plan.push_back(c);
        end
        if (wi >= TIMEOUT) begin
            repeat (3) plan.push_back(mk(7));
            return;
        end
        plan.push_back(mk(1));
        if (c_halt) begin
            repeat (3) plan.push_back(mk(6));
            return;
        end
        m_src = c_jr ? 2 : ((c_uc || (c_bc && c_tk)) ? 1 : 0);
        c = mk(2);
        c.pc_we = !(c_mr || c_mw) && !c_rw;
        plan.push_back(c);
        if (c_mr || c_mw) begin
            for (int i = 0; i <= wd && i < TIMEOUT; i++) begin
                c = mk(3);
                c.dmem_req = 1'b1;
                c.dmem_we = c_mw;
                c.dready = (i == wd);
                c.pc_we = c_mw && (i == wd);
                plan.push_back(c);
            end
            if (wd >= TIMEOUT) begin
                repeat (3) plan.push_back(mk(7));
                return;
            end
        end
        if (c_rw && !c_mw) begin
            c = mk(4);
            c.rf_we = 1'b1;
            c.pc_we = 1'b1;
            plan.push_back(c);
        end
    endtask

    task automatic play(input int n);
        cyc_t c;
        int   lim;
        lim = (n < 0 || n > plan.size()) ? plan.size() : n;
        obs.delete();
        for (int i = 0; i < lim; i++) begin
            c = plan[i];
            @(negedge clk);
            rstn       = 1'b1;
            start      = (c.st == 3'd5) ? c.start  : rbit();
            imem_ready = (c.st == 3'd0) ? c.iready : rbit();
            dmem_ready = (c.st == 3'd3) ? c.dready : rbit();
            if (c.st >= 3'd1 && c.st <= 3'd4) begin
                mem_read = c_mr; mem_write = c_mw; reg_write = c_rw; branch_uc = c_uc;
                branch_c = c_bc; jump_reg = c_jr; halt_instr = c_halt; br_taken = c_tk;
            end else begin
                mem_read = rbit(); mem_write = rbit(); reg_write = rbit(); branch_uc = rbit();
                branch_c = rbit(); jump_reg = rbit(); halt_instr = rbit(); br_taken = rbit();
            end
            c.ret = m_ret;
            exp_q.push_back(c);
            if (c.pc_we) m_ret = (m_ret == (1 << CNT_W) - 1) ? m_ret : m_ret + 1;
            #3 obs.push_back(int'(state));
        end
        plan.delete();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rstn = 1'b0;
        start = rbit(); imem_ready = rbit(); dmem_ready = rbit();
        mem_read = rbit(); mem_write = rbit(); reg_write = rbit(); branch_uc = rbit();
        branch_c = rbit(); jump_reg = rbit(); halt_instr = rbit(); br_taken = rbit();
        m_ret = 0;
        m_src = 0;
    endtask

    always @(negedge clk) begin
        cyc_t e;
        #2;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("state",    32'(state),    32'(e.st));
            chk("imem_req", 32'(imem_req), 32'(e.imem_req));
            chk("ir_we",    32'(ir_we),    32'(e.ir_we));
            chk("dmem_req", 32'(dmem_req), 32'(e.dmem_req));
            chk("dmem_we",  32'(dmem_we),  32'(e.dmem_we));
            chk("rf_we",    32'(rf_we),    32'(e.rf_we));
            chk("pc_we",    32'(pc_we),    32'(e.pc_we));
            chk("pc_src",   32'(pc_src),   32'(e.pc_src));
            chk("busy",     32'(busy),     32'(e.busy));
            chk("err",      32'(err),      32'(e.err));
            chk("retired",  32'(retired),  32'(e.ret));
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        kind_t k;
        int    wi, wd;

        do_reset();
        build_idle(0);
        build_instr(K_ALU, 0, 0, 1'b0);
        chk("t1_len", 32'(plan.size()), 32'd5);
        play(-1);
        for (int i = 0; i < 5; i++) chk("t1_seq", 32'(obs[i]), 32'(t1_exp[i]));
        chk("t1_ret_model", 32'(m_ret), 32'd1);

        build_instr(K_LOAD, 0, 3, 1'b0);
        chk("t2_len", 32'(plan.size()), 32'd8);
        play(-1);
        chk("t2_mem_cycles", 32'(count_state(3)), 32'd4);

        build_instr(K_STORE, 0, 1, 1'b0);
        chk("t3_len", 32'(plan.size()), 32'd5);
        play(-1);

        build_instr(K_BR, 0, 0, 1'b1);
        chk("t4_src_taken", 32'(m_src), 32'd1);
        chk("t4_len", 32'(plan.size()), 32'd3);
        play(-1);
        build_instr(K_BR, 0, 0, 1'b0);
        chk("t4_src_not_taken", 32'(m_src), 32'd0);
        play(-1);

        build_instr(K_JALR, 0, 0, 1'b0);
        chk("t5_src_jalr", 32'(m_src), 32'd2);
        play(-1);
        build_instr(K_HALT, 1, 0, 1'b0);
        play(-1);
        chk("t5_halt_state", 32'(obs[obs.size()-1]), 32'd6);
        chk("t5_ret_model", 32'(m_ret), 32'd6);

        do_reset();
        build_idle(1);
        play(-1);
        repeat (150) begin
            k  = kind_t'($urandom_range(0, 5));
            wi = ($urandom_range(0, 9) == 0) ? TIMEOUT - 1 : $urandom_range(0, 3);
            wd = ($urandom_range(0, 9) == 0) ? TIMEOUT - 1 : $urandom_range(0, 3);
            build_instr(k, wi, wd, rbit());
            play(-1);
        end
        chk("sat_model", 32'(m_ret), 32'd15);

        do_reset();
        build_idle(0);
        build_instr(K_ALU, TIMEOUT, 0, 1'b0);
        play(-1);
        chk("t6_fetch_wait", 32'(count_state(0)), 32'd16);
        chk("t6_err_state", 32'(obs[obs.size()-1]), 32'd7);

        do_reset();
        build_idle(0);
        build_instr(K_ALU, TIMEOUT - 1, 0, 1'b0);
        play(-1);
        chk("t6_ready_on_limit", 32'(obs[17]), 32'd1);
        build_instr(K_STORE, 0, TIMEOUT, 1'b0);
        play(-1);
        chk("t6_dmem_timeout", 32'(obs[obs.size()-1]), 32'd7);

        do_reset();
        build_idle(0);
        build_instr(K_ALU, 0, 0, 1'b0);
        play(-1);
        build_instr(K_LOAD, 0, 6, 1'b0);
        play(5);
        chk("t6_mid_mem", 32'(obs[4]), 32'd3);
        do_reset();
        build_idle(2);
        play(-1);
        chk("t6_after_abort", 32'(obs[0]), 32'd5);
        build_instr(K_HALT, 0, 0, 1'b0);
        play(-1);

        repeat (3) @(negedge clk);
        #4;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
